// File: rtl/initfc_dllp_sequencer.sv
// initfc_dllp_sequencer
//   Sources the InitFC1/InitFC2 DLLP sets while the link is in DL_Init.
//   Each set walks VC0 P,NP,Cpl, VC1 P,... up to NUM_VC-1 Cpl. Every DLLP
//   body carries a freshly sampled credit slice and its CRC16. Sets repeat
//   after a RESEND_INTERVAL idle gap for as long as the link stays in DL_Init.
//
// Ports
//   clk            clock
//   rst_n          synchronous reset, active-low
//   dlc_state_i    link state: 00 inactive, 01 DL_INIT1, 10 DL_INIT2, 11 DL_ACTIVE
//   hdr_credit_i   header credits, slice k = vc*3+type at [k*8 +: 8]
//   data_credit_i  data credits, slice k at [k*12 +: 12]
//   dllp_o         DLLP: [31:0] body, [47:32] CRC16
//   dllp_valid_o   DLLP offered, held stable until accepted
//   dllp_ready_i   TX arbiter accept
//   set_done1_o    pulse: last InitFC1 DLLP of a set accepted
//   set_done2_o    pulse: last InitFC2 DLLP of a set accepted
//
// State | meaning
//   S_IDLE | no DLLP offered, waiting for DL_INIT1/DL_INIT2
//   S_SEND | DLLP at (vc_idx,type_idx) offered on dllp_o
//   S_GAP  | set finished, down-counting the resend gap
module initfc_dllp_sequencer #(
   parameter int          NUM_VC          = 1,
   parameter int          RESEND_INTERVAL = 64,
   parameter logic [15:0] CRC16_POLY      = 16'h100B
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [1:0]               dlc_state_i,
   input  logic [NUM_VC*3*8-1:0]    hdr_credit_i,
   input  logic [NUM_VC*3*12-1:0]   data_credit_i,
   output logic [47:0]              dllp_o,
   output logic                     dllp_valid_o,
   input  logic                     dllp_ready_i,
   output logic                     set_done1_o,
   output logic                     set_done2_o
);

   localparam int NUM_K = NUM_VC * 3;
   localparam int VW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
   localparam int KW    = $clog2(NUM_K);
   localparam int GW    = (RESEND_INTERVAL > 1) ? $clog2(RESEND_INTERVAL) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t          state;
   logic            phase;      // 0 InitFC1, 1 InitFC2
   logic            pend;       // phase changed while a DLLP was held
   logic [VW-1:0]   vc_idx;
   logic [1:0]      type_idx;
   logic [GW-1:0]   gap_cnt;

   logic            init_st;
   logic            chg_now;
   logic            restart;
   logic            hs;
   logic            is_last;
   logic            do_load;
   logic [VW-1:0]   ld_vc;
   logic [1:0]      ld_type;
   logic [KW-1:0]   k;
   logic [7:0]      ld_hdr;
   logic [11:0]     ld_data;
   logic [31:0]     ld_body;
   logic [15:0]     ld_crc;
   logic [47:0]     ld_dllp;

   logic [7:0]      hdr_arr  [NUM_K];
   logic [11:0]     data_arr [NUM_K];

   for (genvar g = 0; g < NUM_K; g++) begin : g_slice
      assign hdr_arr[g]  = hdr_credit_i[g*8 +: 8];
      assign data_arr[g] = data_credit_i[g*12 +: 12];
   end

   // Serial LFSR over byte0..byte3, bit0 first (i.e. body[0] upward), then
   // complemented and bit-reversed.
   function automatic logic [15:0] crc16(input logic [31:0] body);
      logic [15:0] c;
      logic [15:0] r;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 0; i < 32; i++) begin
         fb = c[15] ^ body[i];
         c  = {c[14:0], 1'b0};
         if (fb) c = c ^ CRC16_POLY;
      end
      c = ~c;
      for (int i = 0; i < 16; i++) r[i] = c[15-i];
      return r;
   endfunction

   always_comb begin
      init_st = (dlc_state_i == 2'b01) || (dlc_state_i == 2'b10);
      chg_now = init_st && (dlc_state_i[1] != phase);
      restart = pend || chg_now;
      hs      = dllp_valid_o && dllp_ready_i;
      is_last = (vc_idx == VW'(NUM_VC - 1)) && (type_idx == 2'd2);

      do_load = 1'b0;
      if (init_st) begin
         case (state)
            S_IDLE:  do_load = 1'b1;
            S_SEND:  do_load = hs && (restart || !is_last || (RESEND_INTERVAL == 0));
            S_GAP:   do_load = chg_now || (gap_cnt == '0);
            default: do_load = 1'b0;
         endcase
      end

      // Every load outside of a plain mid-set advance starts a fresh set.
      if ((state != S_SEND) || restart || is_last) begin
         ld_vc   = '0;
         ld_type = 2'd0;
      end else if (type_idx == 2'd2) begin
         ld_vc   = vc_idx + VW'(1);
         ld_type = 2'd0;
      end else begin
         ld_vc   = vc_idx;
         ld_type = type_idx + 2'd1;
      end

      k       = KW'(ld_vc) * KW'(3) + KW'(ld_type);
      ld_hdr  = hdr_arr[k];
      ld_data = data_arr[k];
      // Loads only happen in DL_Init, so dlc_state_i[1] is the phase of the new DLLP.
      ld_body = {ld_data[7:0],
                 ld_hdr[1:0], 2'b00, ld_data[11:8],
                 2'b00, ld_hdr[7:2],
                 dlc_state_i[1], 1'b1, ld_type, 1'b0, 3'(ld_vc)};
      ld_crc  = crc16(ld_body);
      ld_dllp = {ld_crc[7:0], ld_crc[15:8], ld_body};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         phase        <= 1'b0;
         pend         <= 1'b0;
         vc_idx       <= '0;
         type_idx     <= 2'd0;
         gap_cnt      <= '0;
         dllp_o       <= '0;
         dllp_valid_o <= 1'b0;
         set_done1_o  <= 1'b0;
         set_done2_o  <= 1'b0;
      end else begin
         set_done1_o <= 1'b0;
         set_done2_o <= 1'b0;
         if ((state == S_SEND) && hs && is_last && !restart) begin
            set_done1_o <= !phase;
            set_done2_o <= phase;
         end

         if (do_load) begin
            state        <= S_SEND;
            phase        <= dlc_state_i[1];
            pend         <= 1'b0;
            vc_idx       <= ld_vc;
            type_idx     <= ld_type;
            gap_cnt      <= '0;
            dllp_o       <= ld_dllp;
            dllp_valid_o <= 1'b1;
         end else begin
            case (state)
               S_SEND: begin
                  if (hs) begin
                     // Accepted without a follow-on load: end of set or link left DL_Init.
                     dllp_valid_o <= 1'b0;
                     pend         <= 1'b0;
                     if (init_st) begin
                        state   <= S_GAP;
                        gap_cnt <= GW'(RESEND_INTERVAL - 1);
                     end else begin
                        state <= S_IDLE;
                     end
                  end else if (chg_now) begin
                     pend <= 1'b1;
                  end
               end
               S_GAP: begin
                  if (!init_st) state <= S_IDLE;
                  else gap_cnt <= gap_cnt - GW'(1);
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_initfc_dllp_sequencer.sv
module tb_initfc_dllp_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // single-VC instance, 64-cycle gap
   logic        rst_n1;
   logic [1:0]  st1;
   logic [23:0] hdr1;
   logic [35:0] data1;
   logic [47:0] dllp1;
   logic        valid1, ready1, sd1_1, sd2_1;

   // three-VC instance, back-to-back sets
   logic         rst_n3;
   logic [1:0]   st3;
   logic [71:0]  hdr3;
   logic [107:0] data3;
   logic [47:0]  dllp3;
   logic         valid3, ready3, sd1_3, sd2_3;

   initfc_dllp_sequencer #(.NUM_VC(1), .RESEND_INTERVAL(64), .CRC16_POLY(16'h100B)) u1 (
      .clk(clk), .rst_n(rst_n1), .dlc_state_i(st1), .hdr_credit_i(hdr1), .data_credit_i(data1),
      .dllp_o(dllp1), .dllp_valid_o(valid1), .dllp_ready_i(ready1),
      .set_done1_o(sd1_1), .set_done2_o(sd2_1));

   initfc_dllp_sequencer #(.NUM_VC(3), .RESEND_INTERVAL(0), .CRC16_POLY(16'h100B)) u3 (
      .clk(clk), .rst_n(rst_n3), .dlc_state_i(st3), .hdr_credit_i(hdr3), .data_credit_i(data3),
      .dllp_o(dllp3), .dllp_valid_o(valid3), .dllp_ready_i(ready3),
      .set_done1_o(sd1_3), .set_done2_o(sd2_3));

   // Golden CRC16: byte-serial, LSB of each byte first.
   function automatic logic [15:0] bench_crc(input logic [31:0] b);
      logic [15:0] c;
      logic [15:0] r;
      logic [7:0]  by;
      logic        fb;
      c = 16'hFFFF;
      for (int j = 0; j < 4; j++) begin
         by = b[8*j +: 8];
         for (int n = 0; n < 8; n++) begin
            fb = c[15] ^ by[0];
            by = by >> 1;
            c  = c << 1;
            if (fb) c = c ^ 16'h100B;
         end
      end
      c = ~c;
      for (int i = 0; i < 16; i++) r[15-i] = c[i];
      return r;
   endfunction

   function automatic logic [47:0] gold(input int vc, input int typ, input logic ph,
                                        input logic [7:0] h, input logic [11:0] d);
      logic [31:0] b;
      logic [15:0] r;
      b[7:0]   = {ph, 1'b1, 2'(typ), 1'b0, 3'(vc)};
      b[15:8]  = {2'b00, h[7:2]};
      b[23:16] = {h[1:0], 2'b00, d[11:8]};
      b[31:24] = d[7:0];
      r = bench_crc(b);
      return {r[7:0], r[15:8], b};
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid1(input string tag);
      int n;
      n = 0;
      while (!valid1 && n < 200) begin
         tick();
         n++;
      end
      chk(tag, 48'(valid1), 48'd1);
   endtask

   logic [47:0] p_item, np_item, cpl_item, prev_d;
   logic [47:0] exp2 [3];
   logic        prev_held;
   int          acc, cyc, low, it;

   initial begin
      rst_n1 = 1'b0; st1 = 2'b00; ready1 = 1'b0;
      rst_n3 = 1'b0; st3 = 2'b00; ready3 = 1'b0;
      hdr1  = {8'h08, 8'h10, 8'h20};
      data1 = {12'h040, 12'h000, 12'h100};
      for (int q = 0; q < 9; q++) begin
         hdr3[q*8 +: 8]   = 8'(8'h11 * (q + 1));
         data3[q*12 +: 12] = {4'(q), 8'(8'h30 + q)};
      end
      tick(); tick();
      chk("rst_dllp1", dllp1, 48'd0);
      chk("rst_valid1", 48'(valid1), 48'd0);
      chk("rst_done1", 48'({sd1_1, sd2_1}), 48'd0);
      chk("rst_dllp3", dllp3, 48'd0);
      chk("rst_valid3", 48'(valid3), 48'd0);
      rst_n1 = 1'b1; rst_n3 = 1'b1;
      tick();
      chk("idle_valid1", 48'(valid1), 48'd0);

      // 1: basic set, back-to-back, then 64-cycle gap
      p_item   = gold(0, 0, 1'b0, 8'h20, 12'h100);
      np_item  = gold(0, 1, 1'b0, 8'h10, 12'h000);
      cpl_item = gold(0, 2, 1'b0, 8'h08, 12'h040);
      ready1 = 1'b1; st1 = 2'b01;
      tick();
      chk("t1_latency", 48'(valid1), 48'd1);
      chk("t1_p_body", 48'(dllp1[31:0]), 48'h0000_0001_0840);
      chk("t1_p", dllp1, p_item);
      tick();
      chk("t1_np_body", 48'(dllp1[31:0]), 48'h0000_0000_0450);
      chk("t1_np", dllp1, np_item);
      tick();
      chk("t1_cpl_body", 48'(dllp1[31:0]), 48'h0000_4000_0260);
      chk("t1_cpl", dllp1, cpl_item);
      tick();
      chk("t1_done1", 48'(sd1_1), 48'd1);
      chk("t1_done2", 48'(sd2_1), 48'd0);
      chk("t1_gap_valid", 48'(valid1), 48'd0);
      low = 1;
      while (!valid1 && low < 300) begin
         tick();
         if (!valid1) low++;
      end
      chk("t1_gap_len", 48'(low), 48'd64);
      chk("t1_gap_done", 48'(sd1_1), 48'd0);
      chk("t1_repeat_p", dllp1, p_item);

      // 2: credits changed while held, random ready
      ready1 = 1'b0;
      hdr1  = {8'h5A, 8'hC3, 8'hFF};
      data1 = {12'hABC, 12'h123, 12'hFFF};
      tick();
      chk("t2_held0", dllp1, p_item);
      tick();
      chk("t2_held1", dllp1, p_item);
      exp2[0] = p_item;
      exp2[1] = gold(0, 1, 1'b0, 8'hC3, 12'h123);
      exp2[2] = gold(0, 2, 1'b0, 8'h5A, 12'hABC);
      acc = 0; cyc = 0; prev_held = 1'b1; prev_d = p_item;
      while (acc < 3 && cyc < 200) begin
         ready1 = (cyc > 60) ? 1'b1 : 1'($urandom_range(0, 1));
         chk("t2_valid", 48'(valid1), 48'd1);
         if (prev_held) chk("t2_stable", dllp1, prev_d);
         if (ready1) begin
            chk("t2_accept", dllp1, exp2[acc]);
            acc++;
            prev_held = 1'b0;
         end else begin
            prev_held = 1'b1;
            prev_d    = dllp1;
         end
         tick();
         cyc++;
      end
      chk("t2_count", 48'(acc), 48'd3);
      chk("t2_done1", 48'(sd1_1), 48'd1);

      // 4: DL_INIT1 -> DL_INIT2 while an InitFC1 DLLP is held
      ready1 = 1'b0;
      wait_valid1("t4_wait");
      chk("t4_p1", dllp1, gold(0, 0, 1'b0, 8'hFF, 12'hFFF));
      ready1 = 1'b1;
      tick();
      ready1 = 1'b0; st1 = 2'b10;
      chk("t4_np1", dllp1, gold(0, 1, 1'b0, 8'hC3, 12'h123));
      tick();
      chk("t4_np1_held", dllp1, gold(0, 1, 1'b0, 8'hC3, 12'h123));
      chk("t4_np1_type", 48'(dllp1[7:4]), 48'h5);
      tick();
      chk("t4_np1_held2", dllp1, gold(0, 1, 1'b0, 8'hC3, 12'h123));
      ready1 = 1'b1;
      tick();
      chk("t4_p2", dllp1, gold(0, 0, 1'b1, 8'hFF, 12'hFFF));
      chk("t4_p2_type", 48'(dllp1[7:4]), 48'hC);
      chk("t4_no_done1", 48'({sd1_1, sd2_1}), 48'd0);
      tick();
      chk("t4_np2", dllp1, gold(0, 1, 1'b1, 8'hC3, 12'h123));
      chk("t4_no_done1b", 48'(sd1_1), 48'd0);
      tick();
      chk("t4_cpl2", dllp1, gold(0, 2, 1'b1, 8'h5A, 12'hABC));
      tick();
      chk("t4_done2", 48'(sd2_1), 48'd1);
      chk("t4_done1_excl", 48'(sd1_1), 48'd0);
      chk("t4_gap_valid", 48'(valid1), 48'd0);

      // 5: leave DL_Init with a DLLP in flight, then reset mid-SEND
      ready1 = 1'b0;
      wait_valid1("t5_wait");
      st1 = 2'b11;
      tick();
      chk("t5_inflight_valid", 48'(valid1), 48'd1);
      chk("t5_inflight_dllp", dllp1, gold(0, 0, 1'b1, 8'hFF, 12'hFFF));
      ready1 = 1'b1;
      tick();
      chk("t5_idle_valid", 48'(valid1), 48'd0);
      chk("t5_idle_done", 48'({sd1_1, sd2_1}), 48'd0);
      tick();
      chk("t5_idle_stay", 48'(valid1), 48'd0);
      ready1 = 1'b0; st1 = 2'b01;
      tick();
      chk("t5_resend", 48'(valid1), 48'd1);
      rst_n1 = 1'b0;
      tick();
      chk("t5_rst_dllp", dllp1, 48'd0);
      chk("t5_rst_valid", 48'(valid1), 48'd0);
      chk("t5_rst_done", 48'({sd1_1, sd2_1}), 48'd0);
      st1 = 2'b00; rst_n1 = 1'b1;

      // 3: three VCs, no gap between sets
      ready3 = 1'b1; st3 = 2'b01;
      tick();
      for (int i = 0; i <= 18; i++) begin
         it = i % 9;
         chk("t3_valid", 48'(valid3), 48'd1);
         chk("t3_dllp", dllp3, gold(it / 3, it % 3, 1'b0, hdr3[it*8 +: 8], data3[it*12 +: 12]));
         chk("t3_vcid", 48'(dllp3[2:0]), 48'(it / 3));
         chk("t3_done1", 48'(sd1_3), 48'(i > 0 && it == 0));
         chk("t3_done2", 48'(sd2_3), 48'd0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
